// File: rtl/snow_fsm_core.sv
// SNOW 3G style FSM core: F/z word generation with R1..R3 update through
// pipelined S1/S2 word transforms and a valid/ready tap interface.
module snow_fsm_core #(
  parameter int SBOX_LAT = 1,
  parameter int HAS_R3   = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      s0,
  input  logic [31:0]      s5,
  input  logic [31:0]      s15,
  input  logic             load,
  input  logic [31:0]      load_r1,
  input  logic [31:0]      load_r2,
  input  logic [31:0]      load_r3,
  output logic             f_valid,
  output logic [31:0]      f_out,
  output logic [31:0]      z_out,
  output logic             f_is_init,
  output logic [95:0]      fsm_state,
  output logic [CNT_W-1:0] ks_count,
  output logic [1:0]       dbg_state
);

  // Handshake: taps are taken on a cycle where in_valid && in_ready; the
  // source keeps s0/s5/s15/mode stable until then. in_ready is high only in
  // IDLE while load is low, so a load always wins over a coincident in_valid.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_COMMIT = 2'd2} state_t;

  function automatic logic [7:0] mulx(input logic [7:0] v, input logic [7:0] red);
    return v[7] ? ({v[6:0], 1'b0} ^ red) : {v[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] red);
    logic [7:0] acc;
    logic [7:0] t;
    acc = 8'h00;
    t   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ t;
      t = mulx(t, red);
    end
    return acc;
  endfunction

  // AES S-box: inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] sbox_r(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] y;
    p = x;
    y = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p, 8'h1b);
      y = gf_mul(y, p, 8'h1b);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^
           {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  // Dickson-polynomial S-box over GF(2^8) reduced by x^8+x^6+x^5+x^3+1.
  function automatic logic [7:0] sbox_q(input logic [7:0] x);
    logic [7:0] x2, x4, x8, x9, x13, x15, x16, x32, x33, x41, x45, x47, x49;
    x2  = gf_mul(x, x, 8'h69);
    x4  = gf_mul(x2, x2, 8'h69);
    x8  = gf_mul(x4, x4, 8'h69);
    x9  = gf_mul(x8, x, 8'h69);
    x13 = gf_mul(x9, x4, 8'h69);
    x15 = gf_mul(x13, x2, 8'h69);
    x16 = gf_mul(x8, x8, 8'h69);
    x32 = gf_mul(x16, x16, 8'h69);
    x33 = gf_mul(x32, x, 8'h69);
    x41 = gf_mul(x33, x8, 8'h69);
    x45 = gf_mul(x41, x4, 8'h69);
    x47 = gf_mul(x45, x2, 8'h69);
    x49 = gf_mul(x47, x2, 8'h69);
    return x ^ x9 ^ x13 ^ x15 ^ x33 ^ x41 ^ x45 ^ x47 ^ x49 ^ 8'h25;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] y, input logic [7:0] red);
    logic [7:0] a0, a1, a2, a3;
    a0 = y[31:24];
    a1 = y[23:16];
    a2 = y[15:8];
    a3 = y[7:0];
    return {mulx(a0, red) ^ a1 ^ a2 ^ mulx(a3, red) ^ a3,
            mulx(a0, red) ^ a0 ^ mulx(a1, red) ^ a2 ^ a3,
            a0 ^ mulx(a1, red) ^ a1 ^ mulx(a2, red) ^ a3,
            a0 ^ a1 ^ mulx(a2, red) ^ a2 ^ mulx(a3, red)};
  endfunction

  function automatic logic [31:0] s1_fn(input logic [31:0] w);
    return mix({sbox_r(w[31:24]), sbox_r(w[23:16]), sbox_r(w[15:8]), sbox_r(w[7:0])}, 8'h1b);
  endfunction

  function automatic logic [31:0] s2_fn(input logic [31:0] w);
    return mix({sbox_q(w[31:24]), sbox_q(w[23:16]), sbox_q(w[15:8]), sbox_q(w[7:0])}, 8'h69);
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       wait_cnt_q, wait_cnt_d;
  logic [31:0]      r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [31:0]      f_cap_q, f_cap_d, z_cap_q, z_cap_d, r_cap_q, r_cap_d;
  logic             init_cap_q, init_cap_d;
  logic             f_valid_q, f_valid_d, f_is_init_q, f_is_init_d;
  logic [31:0]      f_out_q, f_out_d, z_out_q, z_out_d;
  logic [CNT_W-1:0] ks_q, ks_d;
  logic [31:0]      s1_pipe_q [SBOX_LAT];
  logic [31:0]      s1_pipe_d [SBOX_LAT];
  logic [31:0]      s2_pipe_q [SBOX_LAT];
  logic [31:0]      s2_pipe_d [SBOX_LAT];
  logic [31:0]      f_now;

  assign in_ready  = (state_q == ST_IDLE) && !load;
  assign f_valid   = f_valid_q;
  assign f_out     = f_out_q;
  assign z_out     = z_out_q;
  assign f_is_init = f_is_init_q;
  assign fsm_state = {r3_q, r2_q, r1_q};
  assign ks_count  = ks_q;
  assign dbg_state = state_q;
  assign f_now     = (s15 + r1_q) ^ r2_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    f_cap_d     = f_cap_q;
    z_cap_d     = z_cap_q;
    r_cap_d     = r_cap_q;
    init_cap_d  = init_cap_q;
    f_valid_d   = 1'b0;
    f_out_d     = f_out_q;
    z_out_d     = z_out_q;
    f_is_init_d = f_is_init_q;
    ks_d        = ks_q;
    // R1/R2 only change in COMMIT or on load, so the pipes settle before use.
    s1_pipe_d[0] = s1_fn(r1_q);
    s2_pipe_d[0] = s2_fn(r2_q);
    for (int i = 1; i < SBOX_LAT; i++) begin
      s1_pipe_d[i] = s1_pipe_q[i-1];
      s2_pipe_d[i] = s2_pipe_q[i-1];
    end
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          r1_d = load_r1;
          r2_d = load_r2;
          r3_d = (HAS_R3 != 0) ? load_r3 : 32'h0;
        end else if (in_valid) begin
          f_cap_d    = f_now;
          z_cap_d    = mode ? (f_now ^ s0) : 32'h0;
          r_cap_d    = r2_q + (r3_q ^ s5);
          init_cap_d = ~mode;
          wait_cnt_d = (SBOX_LAT > 1) ? 2'(SBOX_LAT - 2) : 2'd0;
          state_d    = (SBOX_LAT > 1) ? ST_WAIT : ST_COMMIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 2'd0) state_d = ST_COMMIT;
        else wait_cnt_d = wait_cnt_q - 2'd1;
      end
      ST_COMMIT: begin
        r1_d        = r_cap_q;
        r2_d        = s1_pipe_q[SBOX_LAT-1];
        r3_d        = (HAS_R3 != 0) ? s2_pipe_q[SBOX_LAT-1] : 32'h0;
        f_valid_d   = 1'b1;
        f_out_d     = f_cap_q;
        z_out_d     = z_cap_q;
        f_is_init_d = init_cap_q;
        if (!init_cap_q) ks_d = ks_q + CNT_W'(1);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 2'd0;
      r1_q        <= '0;
      r2_q        <= '0;
      r3_q        <= '0;
      f_cap_q     <= '0;
      z_cap_q     <= '0;
      r_cap_q     <= '0;
      init_cap_q  <= 1'b0;
      f_valid_q   <= 1'b0;
      f_out_q     <= '0;
      z_out_q     <= '0;
      f_is_init_q <= 1'b0;
      ks_q        <= '0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        s1_pipe_q[i] <= '0;
        s2_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      f_cap_q     <= f_cap_d;
      z_cap_q     <= z_cap_d;
      r_cap_q     <= r_cap_d;
      init_cap_q  <= init_cap_d;
      f_valid_q   <= f_valid_d;
      f_out_q     <= f_out_d;
      z_out_q     <= z_out_d;
      f_is_init_q <= f_is_init_d;
      ks_q        <= ks_d;
      for (int i = 0; i < SBOX_LAT; i++) begin
        s1_pipe_q[i] <= s1_pipe_d[i];
        s2_pipe_q[i] <= s2_pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_snow_fsm_core.sv
// Bench for snow_fsm_core: default instance plus a SBOX_LAT=3, HAS_R3=0,
// CNT_W=4 instance, both checked against a field-arithmetic reference model.
module tb_snow_fsm_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic [31:0] s0 [2];
  logic [31:0] s5 [2];
  logic [31:0] s15 [2];
  logic        load [2];
  logic [31:0] load_r1 [2];
  logic [31:0] load_r2 [2];
  logic [31:0] load_r3 [2];
  logic        f_valid [2];
  logic [31:0] f_out [2];
  logic [31:0] z_out [2];
  logic        f_is_init [2];
  logic [95:0] fsm_state [2];
  logic [1:0]  dbg_state [2];
  logic [15:0] ks0;
  logic [3:0]  ks1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] m_r1 [2];
  logic [31:0] m_r2 [2];
  logic [31:0] m_r3 [2];
  int          m_ks [2];
  int          lat [2]     = '{1, 3};
  bit          has_r3 [2]  = '{1'b1, 1'b0};
  int          cnt_mod [2] = '{65536, 16};

  always #5 clk = ~clk;

  snow_fsm_core u_dut0 (
    .clk(clk), .reset(reset), .mode(mode[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .s0(s0[0]), .s5(s5[0]), .s15(s15[0]), .load(load[0]), .load_r1(load_r1[0]),
    .load_r2(load_r2[0]), .load_r3(load_r3[0]), .f_valid(f_valid[0]), .f_out(f_out[0]),
    .z_out(z_out[0]), .f_is_init(f_is_init[0]), .fsm_state(fsm_state[0]), .ks_count(ks0),
    .dbg_state(dbg_state[0]));

  snow_fsm_core #(.SBOX_LAT(3), .HAS_R3(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .mode(mode[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .s0(s0[1]), .s5(s5[1]), .s15(s15[1]), .load(load[1]), .load_r1(load_r1[1]),
    .load_r2(load_r2[1]), .load_r3(load_r3[1]), .f_valid(f_valid[1]), .f_out(f_out[1]),
    .z_out(z_out[1]), .f_is_init(f_is_init[1]), .fsm_state(fsm_state[1]), .ks_count(ks1),
    .dbg_state(dbg_state[1]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input int poly);
    logic [14:0] prod;
    logic [14:0] pm;
    prod = '0;
    pm   = 15'(poly);
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (prod[i]) prod = prod ^ (pm << (i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_sr(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    inv = 8'h00;
    c   = 8'h63;
    for (int y = 1; y < 256; y++) if (x != 0 && ref_mul(x, 8'(y), 'h11b) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return b;
  endfunction

  function automatic logic [7:0] ref_sq(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] acc;
    p   = 8'h01;
    acc = 8'h25;
    for (int k = 1; k <= 49; k++) begin
      p = ref_mul(p, x, 'h169);
      if (k == 1 || k == 9 || k == 13 || k == 15 || k == 33 || k == 41 || k == 45 ||
          k == 47 || k == 49) acc = acc ^ p;
    end
    return acc;
  endfunction

  // circulant matrix rows [2 1 1 3] rotated right per row
  function automatic logic [31:0] ref_word(input logic [31:0] w, input bit use_q);
    logic [7:0] a [4];
    logic [7:0] r [4];
    int poly;
    int off;
    logic [7:0] cf;
    poly = use_q ? 'h169 : 'h11b;
    for (int k = 0; k < 4; k++) a[k] = use_q ? ref_sq(w[31-8*k -: 8]) : ref_sr(w[31-8*k -: 8]);
    for (int row = 0; row < 4; row++) begin
      r[row] = 8'h00;
      for (int col = 0; col < 4; col++) begin
        off = (col - row + 4) % 4;
        cf  = (off == 0) ? 8'h02 : (off == 3) ? 8'h03 : 8'h01;
        r[row] = r[row] ^ ref_mul(cf, a[col], poly);
      end
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic int get_ks(input int d);
    return (d == 0) ? int'(ks0) : int'(ks1);
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mode[d] = 1'b0; in_valid[d] = 1'b0; load[d] = 1'b0;
      s0[d] = '0; s5[d] = '0; s15[d] = '0;
      load_r1[d] = '0; load_r2[d] = '0; load_r3[d] = '0;
      m_r1[d] = '0; m_r2[d] = '0; m_r3[d] = '0; m_ks[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic do_load(input int d, input logic [31:0] l1, input logic [31:0] l2,
                         input logic [31:0] l3, input bit with_valid, input bit md,
                         input logic [31:0] a0, input logic [31:0] a5, input logic [31:0] a15);
    load[d] = 1'b1; load_r1[d] = l1; load_r2[d] = l2; load_r3[d] = l3;
    if (with_valid) begin
      in_valid[d] = 1'b1; mode[d] = md; s0[d] = a0; s5[d] = a5; s15[d] = a15;
    end
    #1;
    chk("load_blocks_ready", 96'(in_ready[d]), 96'(0));
    @(posedge clk);
    @(negedge clk);
    load[d] = 1'b0;
    m_r1[d] = l1; m_r2[d] = l2; m_r3[d] = has_r3[d] ? l3 : 32'h0;
    chk("load_state", fsm_state[d], {m_r3[d], m_r2[d], m_r1[d]});
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_word(input int d, input bit md, input logic [31:0] a0,
                         input logic [31:0] a5, input logic [31:0] a15,
                         output logic [31:0] got_f, output logic [31:0] got_z,
                         output logic got_init);
    logic [31:0] ef, ez, rn;
    int n;
    ef = (a15 + m_r1[d]) ^ m_r2[d];
    ez = md ? (ef ^ a0) : 32'h0;
    rn = m_r2[d] + (m_r3[d] ^ a5);
    in_valid[d] = 1'b1; mode[d] = md; s0[d] = a0; s5[d] = a5; s15[d] = a15;
    #1;
    chk("in_ready_idle", 96'(in_ready[d]), 96'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid[d] = 1'b0;
    s0[d] = $urandom(); s5[d] = $urandom(); s15[d] = $urandom();
    n = 0;
    while (f_valid[d] !== 1'b1 && n < 8) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", 96'(n), 96'(lat[d]));
    m_r3[d] = has_r3[d] ? ref_word(m_r2[d], 1'b1) : 32'h0;
    m_r2[d] = ref_word(m_r1[d], 1'b0);
    m_r1[d] = rn;
    if (md) m_ks[d] = (m_ks[d] + 1) % cnt_mod[d];
    got_f = f_out[d]; got_z = z_out[d]; got_init = f_is_init[d];
    chk("f_out", 96'(f_out[d]), 96'(ef));
    chk("z_out", 96'(z_out[d]), 96'(ez));
    chk("f_is_init", 96'(f_is_init[d]), 96'(!md));
    chk("fsm_state", fsm_state[d], {m_r3[d], m_r2[d], m_r1[d]});
    chk("ks_count", 96'(get_ks(d)), 96'(m_ks[d]));
    @(posedge clk);
    @(negedge clk);
    chk("f_valid_pulse", 96'(f_valid[d]), 96'(0));
    chk("f_out_hold", {f_out[d], z_out[d]}, 96'({ef, ez}));
  endtask

  typedef struct {
    bit          do_ld;
    logic [31:0] l1, l2, l3;
    bit          md;
    logic [31:0] a0, a5, a15;
    logic [31:0] ef, ez;
    bit          einit;
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [31:0] gf, gz;
    logic        gi;
    int          ks_before;

    tbl[0] = '{1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h5, 32'h2, 32'h1, 32'h1, 32'h4, 1'b0};
    tbl[1] = '{1'b1, 32'h1, 32'h12345678, 32'h0, 1'b0, 32'h0, 32'h0, 32'hffffffff,
               32'h12345678, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 32'h10, 32'hf0f0f0f0, 32'h0, 1'b1, 32'hffffffff, 32'h7, 32'h20,
               32'hf0f0f0c0, 32'h0f0f0f3f, 1'b0};
    tbl[3] = '{1'b1, 32'h80000000, 32'h0, 32'h0, 1'b1, 32'h1234, 32'h9, 32'h80000000,
               32'h0, 32'h1234, 1'b0};

    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_state", fsm_state[d], 96'h0);
      chk("rst_outs", {f_out[d], z_out[d]}, 96'h0);
      chk("rst_flags", 96'({f_valid[d], f_is_init[d], in_ready[d], dbg_state[d]}), 96'(5'b00100));
      chk("rst_ks", 96'(get_ks(d)), 96'(0));
    end

    // directed table on the default instance
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].do_ld) do_load(0, tbl[i].l1, tbl[i].l2, tbl[i].l3, 1'b0, 1'b0, 0, 0, 0);
      ks_before = get_ks(0);
      do_word(0, tbl[i].md, tbl[i].a0, tbl[i].a5, tbl[i].a15, gf, gz, gi);
      chk("tbl_f", 96'(gf), 96'(tbl[i].ef));
      chk("tbl_z", 96'(gz), 96'(tbl[i].ez));
      chk("tbl_init", 96'(gi), 96'(tbl[i].einit));
      chk("tbl_ks_step", 96'(get_ks(0) - ks_before), 96'(tbl[i].md));
      if (i == 0) chk("sbox_of_zero", fsm_state[0], {32'h25252525, 32'h63636363, 32'h2});
    end

    // load and in_valid together: load wins, taps accepted next cycle
    do_load(0, 32'hdeadbeef, 32'h01020304, 32'h55aa55aa, 1'b1, 1'b1, 32'h3, 32'h4, 32'h5);
    do_word(0, 1'b1, 32'h3, 32'h4, 32'h5, gf, gz, gi);
    chk("coincident_f", 96'(gf), 96'((32'h5 + 32'hdeadbeef) ^ 32'h01020304));

    // randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 4) == 0)
          do_load(d, $urandom(), $urandom(), $urandom(), 1'b0, 1'b0, 0, 0, 0);
        do_word(d, 1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom(), gf, gz, gi);
      end
    end

    // counter wrap on the 4-bit instance with R3 held at zero
    do_reset();
    for (int i = 0; i < 17; i++)
      do_word(1, 1'b1, $urandom(), $urandom(), $urandom(), gf, gz, gi);
    chk("ks_wrap", 96'(ks1), 96'(1));
    chk("r3_zero", 96'(fsm_state[1][95:64]), 96'(0));

    // reset one cycle after accept aborts the update
    do_load(1, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 0, 0, 0);
    in_valid[1] = 1'b1; mode[1] = 1'b1; s0[1] = 32'h1; s5[1] = 32'h2; s15[1] = 32'h3;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid_rst", 96'(f_valid[1]), 96'(0));
    end
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_r1[d] = '0; m_r2[d] = '0; m_r3[d] = '0; m_ks[d] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 96'(f_valid[1]), 96'(0));
    end
    chk("abort_state", fsm_state[1], 96'h0);
    chk("abort_ready", 96'(in_ready[1]), 96'(1));
    chk("abort_ks", 96'(ks1), 96'(0));
    do_word(1, 1'b1, 32'h5, 32'h2, 32'h1, gf, gz, gi);
    chk("after_abort_f", 96'(gf), 96'(32'h1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snow_fsm_core.md
SNOW_FSM_CORE -- requirements
Module: snow_fsm_core

Interface
REQ-001 SHALL have parameter SBOX_LAT, default 1: registered latency in cycles of each S-box path; legal range 1..3.
REQ-002 SHALL have parameter HAS_R3, default 1: 1 selects 3-register FSM (R1,R2,R3), 0 selects 2-register FSM (R3 held at 0).
REQ-003 SHALL have parameter CNT_W, default 16: width of the keystream word counter.
REQ-004 SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1: 0 = initialisation, 1 = keystream; sampled on accept.
REQ-007 SHALL have port in_valid, input, 1: LFSR taps valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept taps.
REQ-009 SHALL have ports s0, s5, s15, input, 32 each: LFSR stages 0, 5 and 15.
REQ-010 SHALL have port load, input, 1: preload FSM registers from load_r1/load_r2/load_r3 (each input, 32).
REQ-011 SHALL have port f_valid, output, 1: one-cycle pulse qualifying f_out, z_out, f_is_init.
REQ-012 SHALL have ports f_out and z_out, output, 32 each: FSM word F and keystream word z.
REQ-013 SHALL have port f_is_init, output, 1: the word was produced in initialisation mode.
REQ-014 SHALL have port fsm_state, output, 96: {R3,R2,R1}.
REQ-015 SHALL have port ks_count, output, CNT_W: count of keystream words emitted.

Function
REQ-016 SHALL instantiate the S1 and S2 transforms, with S1 driven by R1 and S2 by R2, each with SBOX_LAT registered stages.
REQ-017 SHALL implement states IDLE, WAIT and COMMIT; in_ready = 1 only in IDLE with load low.
REQ-018 SHALL accept taps on in_valid & in_ready.
REQ-019 On accept, SHALL capture F = (s15 + R1) mod 2^32 XOR R2 and r = (R2 + (R3 XOR s5)) mod 2^32, with carries discarded, and move to WAIT.
REQ-020 SHALL stay in WAIT for SBOX_LAT-1 cycles (COMMIT immediately when SBOX_LAT = 1), then enter COMMIT.
REQ-021 In COMMIT, SHALL update R3 <= S2(R2) (0 if HAS_R3 = 0), R2 <= S1(R1) and R1 <= r, all from values captured before the update.
REQ-022 In COMMIT, SHALL pulse f_valid, present f_out = F, present z_out = F XOR s0-at-accept in keystream mode or 0 in initialisation mode, set f_is_init = NOT mode, and return to IDLE.
REQ-023 Latency from accept to f_valid SHALL be SBOX_LAT cycles; throughput SHALL be one word per SBOX_LAT+1 cycles.
REQ-024 f_out, z_out and f_is_init SHALL hold their last values until the next f_valid.
REQ-025 ks_count SHALL increment on each f_valid with mode = 1 and wrap from 2^CNT_W-1 to 0.
REQ-026 load in IDLE SHALL write R1..R3 on the next edge (R3 forced to 0 if HAS_R3 = 0) and block accept that cycle; load takes priority over a coincident in_valid.
REQ-027 load in WAIT or COMMIT SHALL be ignored.
REQ-028 in_valid in WAIT or COMMIT SHALL be ignored; the source holds its taps until accepted.
REQ-029 The S-box inputs SHALL be stable for at least SBOX_LAT cycles before COMMIT samples them.

Reset
REQ-030 reset SHALL asynchronously force IDLE, R1 = R2 = R3 = 0, f_out = z_out = 0, f_valid = 0, f_is_init = 0, ks_count = 0 and all S-box pipeline stages to 0.
REQ-031 reset asserted in WAIT or COMMIT SHALL abort the update with no f_valid pulse; the first accept after release starts from zeroed registers.

Verification
REQ-032 After reset, mode = 1, s15 = 0x00000001, s5 = 0x00000002, s0 = 0x00000005 -> after SBOX_LAT cycles f_out = 0x00000001, z_out = 0x00000004, R1 = 0x00000002, R2 = S1(0), R3 = S2(0), ks_count = 1.
REQ-033 Load R1 = 0x00000001, R2 = 0x12345678, R3 = 0; then s15 = 0xFFFFFFFF, mode = 0 -> f_out = 0x12345678 (sum wraps to 0), z_out = 0, f_is_init = 1, ks_count unchanged.
REQ-034 load and in_valid high in the same IDLE cycle -> registers take the load values, in_ready = 0, and the taps are accepted on the following cycle.
REQ-035 Reset asserted one cycle after accept with SBOX_LAT = 3 -> no f_valid, fsm_state = 0, in_ready = 1 after release.
REQ-036 CNT_W = 4, 17 keystream accepts -> ks_count reads 1 after wrap; HAS_R3 = 0 -> R3 reads 0 throughout and r = R2 + s5.
